// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sequencer: opcodes, FSM states and instruction field layout.
package ula_pkg;

    localparam int NREG = 8;
    localparam int W    = 16;
    localparam int AW   = $clog2(NREG);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    // Instruction layout: [15:13] op, [12:10] rd, [9:7] ra, [6:4] rb, [3:0] reserved
    localparam int OP_LSB = 13;
    localparam int RD_LSB = 10;
    localparam int RA_LSB = 7;
    localparam int RB_LSB = 4;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_EX, S_WB} state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/ula_ctrl_if.sv
// Instruction, host-access and ULA-side signals of the sequencer, bundled for port connection.
interface ula_ctrl_if #(parameter int W = 16, parameter int AW = 3);

    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [W-1:0]  host_wdata;
    logic [W-1:0]  host_rdata;
    logic [2:0]    ula_op;
    logic [W-1:0]  ula_a;
    logic [W-1:0]  ula_b;
    logic [W-1:0]  ula_s;
    logic          done;
    logic          err;
    logic [15:0]   retired;

    modport slave (
        input  instr_valid, instr, host_we, host_addr, host_wdata, ula_s,
        output instr_ready, host_rdata, ula_op, ula_a, ula_b, done, err, retired
    );

    modport master (
        output instr_valid, instr, host_we, host_addr, host_wdata, ula_s,
        input  instr_ready, host_rdata, ula_op, ula_a, ula_b, done, err, retired
    );

endinterface

// File: rtl/ula_ctrl_reg_bank.sv
// NREG x W register bank: one synchronous write port, two operand read ports and a host read port.
module reg_bank #(
    parameter int NREG = 8,
    parameter int W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [W-1:0]            wdata,
    input  logic [$clog2(NREG)-1:0] ra_addr,
    input  logic [$clog2(NREG)-1:0] rb_addr,
    input  logic [$clog2(NREG)-1:0] host_addr,
    output logic [W-1:0]            ra_data,
    output logic [W-1:0]            rb_data,
    output logic [W-1:0]            host_data
);

    logic [NREG-1:0][W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data   = mem[ra_addr];
    assign rb_data   = mem[rb_addr];
    assign host_data = mem[host_addr];

endmodule

// File: rtl/ula_ctrl.sv
// Four-state sequencer: accept instruction, read operands, drive the external ULA, write back.
module ula_ctrl
    import ula_pkg::*;
#(
    parameter int NREG = 8,
    parameter int W    = 16
) (
    input  logic      clk,
    input  logic      rst,
    ula_ctrl_if.slave bus
);

    localparam int LAW = $clog2(NREG);

    state_t          state, next;
    logic [15:0]     ir;
    logic [W-1:0]    opa, opb, res;
    logic [15:0]     retired_q;

    logic [2:0]      op_f;
    logic [LAW-1:0]  rd_f, ra_f, rb_f;
    logic            legal, accept;
    logic            bank_we;
    logic [LAW-1:0]  bank_waddr;
    logic [W-1:0]    bank_wdata;
    logic [W-1:0]    ra_data, rb_data, host_data;
    logic            unused_rsvd;

    assign op_f        = ir[OP_LSB +: 3];
    assign rd_f        = ir[RD_LSB +: LAW];
    assign ra_f        = ir[RA_LSB +: LAW];
    assign rb_f        = ir[RB_LSB +: LAW];
    assign unused_rsvd = ^ir[3:0];
    assign legal       = op_legal(op_f);

    // Host writes take priority over instruction issue in IDLE.
    assign bus.instr_ready = (state == S_IDLE) && !bus.host_we;
    assign accept          = bus.instr_ready && bus.instr_valid;

    always_comb begin
        next = state;
        case (state)
            S_IDLE: if (accept) next = S_RD;
            S_RD:   next = legal ? S_EX : S_IDLE;
            S_EX:   next = S_WB;
            S_WB:   next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir        <= '0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            retired_q <= '0;
        end else begin
            if (accept) ir <= bus.instr;
            if (state == S_RD && legal) begin
                opa <= ra_data;
                opb <= rb_data;
            end
            if (state == S_EX) res <= bus.ula_s;
            if (state == S_WB) retired_q <= retired_q + 16'd1;
        end
    end

    // Host and writeback share one port; they live in disjoint states so never collide.
    assign bank_we    = (state == S_WB) || (state == S_IDLE && bus.host_we);
    assign bank_waddr = (state == S_WB) ? rd_f : bus.host_addr;
    assign bank_wdata = (state == S_WB) ? res  : bus.host_wdata;

    reg_bank #(.NREG(NREG), .W(W)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .we        (bank_we),
        .waddr     (bank_waddr),
        .wdata     (bank_wdata),
        .ra_addr   (ra_f),
        .rb_addr   (rb_f),
        .host_addr (bus.host_addr),
        .ra_data   (ra_data),
        .rb_data   (rb_data),
        .host_data (host_data)
    );

    // Operands come only from registers; outside EX the ULA sees a safe AND of zeros.
    assign bus.ula_op     = (state == S_EX) ? op_f : OP_AND;
    assign bus.ula_a      = (state == S_EX) ? opa  : '0;
    assign bus.ula_b      = (state == S_EX) ? opb  : '0;

    assign bus.host_rdata = host_data;
    assign bus.done       = (state == S_WB);
    assign bus.err        = (state == S_RD) && !legal;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed scoreboard bench for ula_ctrl with a behavioural ULA attached to its operand outputs.
module tb_ula_ctrl;
    import ula_pkg::*;

    typedef struct {
        bit          is_err;
        int          lat;
        logic [15:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ula_ctrl_if #(.W(16), .AW(3)) bus();

    ula_ctrl #(.NREG(8), .W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External combinational ULA
    always_comb begin
        bus.ula_s = 16'h0000;
        case (bus.ula_op)
            OP_ADD: bus.ula_s = bus.ula_a + bus.ula_b;
            OP_SUB: bus.ula_s = bus.ula_a - bus.ula_b;
            OP_AND: bus.ula_s = bus.ula_a & bus.ula_b;
            OP_OR:  bus.ula_s = bus.ula_a | bus.ula_b;
            OP_XOR: bus.ula_s = bus.ula_a ^ bus.ula_b;
            default: bus.ula_s = 16'h0000;
        endcase
    end

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    bit          ret_chk = 0;
    logic [15:0] ret_exp = 16'h0;
    logic [15:0] exp_ret = 16'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 4'b0000};
    endfunction

    // Cycle counter and handshake timestamp
    initial forever begin
        @(posedge clk);
        if (bus.instr_valid && bus.instr_ready) hs_cyc = cyc;
        cyc = cyc + 1;
    end

    // Monitor: pops an expectation for every done/err pulse, checks retired the cycle after
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            ret_chk = 0;
        end else begin
            if (ret_chk) begin
                chk("retired", {16'h0, bus.retired}, {16'h0, ret_exp});
                ret_chk = 0;
            end
            if (bus.done || bus.err) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: done=%b err=%b, none expected", bus.done, bus.err);
                end else begin
                    e = q.pop_front();
                    chk("err_pulse", {31'h0, bus.err}, {31'h0, e.is_err});
                    chk("done_pulse", {31'h0, bus.done}, {31'h0, !e.is_err});
                    chk("latency", cyc - hs_cyc, e.lat);
                    ret_exp = e.ret;
                    ret_chk = 1;
                end
            end
        end
    end

    task automatic hwrite(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.host_we    = 1'b1;
        bus.host_addr  = a;
        bus.host_wdata = d;
        @(negedge clk);
        bus.host_we    = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [15:0] exp);
        @(negedge clk);
        bus.host_addr = a;
        #1;
        chk(nm, {16'h0, bus.host_rdata}, {16'h0, exp});
    endtask

    // Caller is just after a negedge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, input bit track);
        int n;
        n = 0;
        bus.instr       = mk(op, rd, ra, rb);
        bus.instr_valid = 1'b1;
        #1;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.instr_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: instr_ready stuck at %b", bus.instr_ready);
        end else if (track) begin
            if (op_legal(op)) begin
                exp_ret = exp_ret + 16'd1;
                q.push_back('{is_err: 1'b0, lat: 3, ret: exp_ret});
            end else begin
                q.push_back('{is_err: 1'b1, lat: 1, ret: exp_ret});
            end
        end
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || ret_chk) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_timeout: %0d responses still outstanding", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0;
        bus.host_we     = 1'b0;
        bus.host_addr   = 3'd0;
        bus.host_wdata  = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready",   {31'h0, bus.instr_ready}, 32'd1);
        chk("rst_done",    {31'h0, bus.done}, 32'd0);
        chk("rst_err",     {31'h0, bus.err}, 32'd0);
        chk("rst_retired", {16'h0, bus.retired}, 32'd0);
        chk("rst_ula_op",  {29'h0, bus.ula_op}, 32'd2);
        chk("rst_ula_a",   {16'h0, bus.ula_a}, 32'd0);
        chk("rst_ula_b",   {16'h0, bus.ula_b}, 32'd0);
        for (int r = 0; r < 8; r++) rd_chk("rst_bank", r[2:0], 16'h0000);

        // ADD with signed-overflow boundary
        hwrite(3'd1, 16'h7FFF);
        hwrite(3'd2, 16'h0001);
        @(negedge clk); send(OP_ADD, 3'd3, 3'd1, 3'd2, 1);
        wait_idle();
        rd_chk("add_r3", 3'd3, 16'h8000);

        // SUB wrapping negative, then logic ops
        hwrite(3'd4, 16'h0003);
        hwrite(3'd5, 16'h0005);
        @(negedge clk); send(OP_SUB, 3'd6, 3'd4, 3'd5, 1);
        wait_idle();
        rd_chk("sub_r6", 3'd6, 16'hFFFE);
        hwrite(3'd1, 16'hF0F0);
        hwrite(3'd2, 16'h0FF0);
        @(negedge clk); send(OP_AND, 3'd3, 3'd1, 3'd2, 1);
        wait_idle();
        @(negedge clk); send(OP_OR, 3'd4, 3'd1, 3'd2, 1);
        wait_idle();
        @(negedge clk); send(OP_XOR, 3'd5, 3'd1, 3'd2, 1);
        wait_idle();
        rd_chk("and_r3", 3'd3, 16'h00F0);
        rd_chk("or_r4",  3'd4, 16'hFFF0);
        rd_chk("xor_r5", 3'd5, 16'hFF00);

        // Illegal opcode: err only, bank untouched
        @(negedge clk); send(3'b110, 3'd7, 3'd1, 3'd2, 1);
        wait_idle();
        rd_chk("illegal_r7", 3'd7, 16'h0000);
        rd_chk("illegal_r5", 3'd5, 16'hFF00);
        rd_chk("illegal_r1", 3'd1, 16'hF0F0);

        // Host write collides with instruction in IDLE: host wins, instruction next cycle
        @(negedge clk);
        bus.host_we     = 1'b1;
        bus.host_addr   = 3'd0;
        bus.host_wdata  = 16'h1234;
        bus.instr       = mk(OP_ADD, 3'd6, 3'd0, 3'd0);
        bus.instr_valid = 1'b1;
        #1;
        chk("ready_vs_host", {31'h0, bus.instr_ready}, 32'd0);
        @(negedge clk);
        bus.host_we = 1'b0;
        send(OP_ADD, 3'd6, 3'd0, 3'd0, 1);
        wait_idle();
        rd_chk("host_r0", 3'd0, 16'h1234);
        rd_chk("after_host_r6", 3'd6, 16'h2468);

        // Reset during EX abandons the instruction
        @(negedge clk); send(OP_ADD, 3'd7, 3'd1, 3'd2, 0);
        @(posedge clk); #1;
        chk("ex_ula_op", {29'h0, bus.ula_op}, {29'h0, OP_ADD});
        chk("ex_ula_a",  {16'h0, bus.ula_a}, 32'h0000F0F0);
        chk("ex_ula_b",  {16'h0, bus.ula_b}, 32'h00000FF0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 16'h0;
        @(negedge clk);
        chk("midrst_ready",   {31'h0, bus.instr_ready}, 32'd1);
        chk("midrst_done",    {31'h0, bus.done}, 32'd0);
        chk("midrst_retired", {16'h0, bus.retired}, 32'd0);
        chk("midrst_ula_op",  {29'h0, bus.ula_op}, 32'd2);
        chk("midrst_ula_a",   {16'h0, bus.ula_a}, 32'd0);
        chk("midrst_ula_b",   {16'h0, bus.ula_b}, 32'd0);
        repeat (4) @(negedge clk);
        chk("midrst_no_done", {31'h0, bus.done}, 32'd0);
        rd_chk("midrst_r7", 3'd7, 16'h0000);

        // Counter wrap, and rd == ra == rb reads the old value
        hwrite(3'd1, 16'h4001);
        @(negedge clk);
        force dut.retired_q = 16'hFFFF;
        @(negedge clk);
        release dut.retired_q;
        @(negedge clk);
        chk("preload_retired", {16'h0, bus.retired}, 32'h0000FFFF);
        exp_ret = 16'hFFFF;
        send(OP_ADD, 3'd1, 3'd1, 3'd1, 1);
        wait_idle();
        rd_chk("self_add_r1", 3'd1, 16'h8002);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
